// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RISC-V byte/halfword/word load-store stage. Takes the ALU
//               result as effective address, drives a single-outstanding
//               req/ack data bus and returns sign/zero-extended load data.
//               Misaligned and illegal accesses fault without a bus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic            misaligned,
  output logic            illegal,
  output logic [XLEN-1:0] load_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_is_store;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_store_data;
  logic            r_misaligned;
  logic            r_illegal;
  logic [XLEN-1:0] r_load_data;

  logic            w_illegal;
  logic            w_misaligned;
  logic            w_accept;
  logic [1:0]      w_off;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_ext;
  logic [XLEN-1:0] w_wdata;
  logic [3:0]      w_wstrb;

  // Decode of the incoming request: only meaningful while accepting in IDLE.
  // Stores have no unsigned variants, so any funct3[2]=1 store is illegal.
  assign w_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                        (funct3 == 3'b111) || (is_store && funct3[2]);
  assign w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
  assign w_accept     = (r_state == S_IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; faults skip the bus cycle and go straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (w_illegal || w_misaligned) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (mem_ack) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture: operands and fault flags are frozen for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_store_data <= '0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_is_store   <= is_store;
      r_funct3     <= funct3;
      r_addr       <= addr;
      r_store_data <= store_data;
      r_illegal    <= w_illegal;
      r_misaligned <= w_misaligned && !w_illegal;
    end
  end

  // Load alignment and extension from the addressed byte lane.
  assign w_off     = r_addr[1:0];
  assign w_shifted = mem_rdata >> {w_off, 3'b000};

  // Extension selected by the latched width code.
  always_comb begin
    w_load_ext = w_shifted;
    case (r_funct3)
      3'b000:  w_load_ext = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_load_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  // Store lane replication and byte strobes.
  always_comb begin
    w_wdata = r_store_data;
    w_wstrb = 4'b1111;
    case (r_funct3[1:0])
      2'b00: begin
        w_wdata = {4{r_store_data[7:0]}};
        w_wstrb = 4'b0001 << w_off;
      end
      2'b01: begin
        w_wdata = {2{r_store_data[15:0]}};
        w_wstrb = w_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = r_store_data;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Load result register: only updated by a completed load.
  always_ff @(posedge clk) begin
    if (reset)                                          r_load_data <= '0;
    else if (r_state == S_REQ && mem_ack && !r_is_store) r_load_data <= w_load_ext;
  end

  // Bus outputs are gated to REQ so the bus is quiet in IDLE/DONE.
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign misaligned = done && r_misaligned;
  assign illegal    = done && r_illegal;
  assign load_data  = r_load_data;
  assign mem_req    = (r_state == S_REQ);
  assign mem_we     = mem_req && r_is_store;
  assign mem_addr   = mem_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata  = mem_we ? w_wdata : '0;
  assign mem_wstrb  = mem_we ? w_wstrb : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a transaction
//               level reference model, directed cases and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        illegal;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_load;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_we;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .misaligned(misaligned), .illegal(illegal),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: extended load value from the architectural rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a[1:0]);
    case (f3)
      3'b000:  ref_load = (s[7:0]  >= 8'h80)    ? (s[7:0]  | 32'hFFFFFF00) : {24'h0, s[7:0]};
      3'b100:  ref_load = s & 32'h000000FF;
      3'b001:  ref_load = (s[15:0] >= 16'h8000) ? (s[15:0] | 32'hFFFF0000) : {16'h0, s[15:0]};
      3'b101:  ref_load = s & 32'h0000FFFF;
      default: ref_load = rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'b000:  ref_wdata = sd[7:0]  * 32'h01010101;
      3'b001:  ref_wdata = sd[15:0] * 32'h00010001;
      default: ref_wdata = sd;
    endcase
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [1:0] o);
    case (f3)
      3'b000:  ref_wstrb = 4'(1 << o);
      3'b001:  ref_wstrb = 4'(3 << o);
      default: ref_wstrb = 4'hF;
    endcase
  endfunction

  // One complete access; checks every cycle from start until back in IDLE.
  task automatic access(input bit st, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] sd, input bit [31:0] rd, input int dly,
                        input bit noise);
    bit ill, mis;
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3 >= 3'b100);
    mis = !ill && (((f3 == 3'b001 || f3 == 3'b101) && a[0]) ||
                   (f3 == 3'b010 && (a % 4) != 0));
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (noise) begin
      is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    end
    if (ill || mis) begin
      chk("fault_done", 32'(done), 1);
      chk("fault_busy", 32'(busy), 1);
      chk("fault_illegal", 32'(illegal), 32'(ill));
      chk("fault_misaligned", 32'(misaligned), 32'(mis));
      chk("fault_no_req", 32'(mem_req), 0);
      chk("fault_load_hold", load_data, m_load);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        chk("req_mem_req", 32'(mem_req), 1);
        chk("req_busy", 32'(busy), 1);
        chk("req_done", 32'(done), 0);
        chk("req_we", 32'(mem_we), 32'(st));
        chk("req_addr", mem_addr, a & 32'hFFFFFFFC);
        chk("req_wstrb", 32'(mem_wstrb), st ? 32'(ref_wstrb(f3, a[1:0])) : 0);
        if (st) chk("req_wdata", mem_wdata, ref_wdata(f3, sd));
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb; obs_we = mem_we;
        start     = noise ? 1'($urandom) : 1'b0;
        mem_ack   = (i == dly);
        mem_rdata = (i == dly) ? rd : $urandom;
        @(posedge clk); #1;
      end
      mem_ack = 1'b0; start = 1'b0;
      if (!st) m_load = ref_load(f3, a, rd);
      chk("cmp_done", 32'(done), 1);
      chk("cmp_no_req", 32'(mem_req), 0);
      chk("cmp_flags", {30'h0, misaligned, illegal}, 0);
      chk("cmp_load_data", load_data, m_load);
    end
    start   = noise ? 1'($urandom) : 1'b0;
    mem_ack = noise ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_req", 32'(mem_req), 0);
    chk("idle_load_data", load_data, m_load);
    start = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0; m_load = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {26'h0, busy, done, misaligned, illegal, mem_req, mem_we}, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_bus", mem_addr | mem_wdata | 32'(mem_wstrb), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Hand-computed expectations.
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    chk("pin_lw_addr", obs_addr, 32'h100);
    chk("pin_lw_wstrb", 32'(obs_wstrb), 0);
    chk("pin_lw", load_data, 32'hDEADBEEF);
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 1'b0);
    chk("pin_lb", load_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0);
    chk("pin_lbu", load_data, 32'h00000080);
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 2, 1'b0);
    chk("pin_lhu", load_data, 32'h000080FF);
    access(1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 0, 1'b0);
    chk("pin_sh_addr", obs_addr, 32'h204);
    chk("pin_sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("pin_sh_wstrb", 32'(obs_wstrb), 32'hC);
    chk("pin_sh_we", 32'(obs_we), 1);
    chk("pin_sh_load_hold", load_data, 32'h000080FF);
    access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b0);
    chk("pin_lw_mis", 32'(misaligned), 0);
    access(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 1'b0);
    access(1'b0, 3'b001, 32'h201, 32'h0, 32'h0, 0, 1'b0);
    access(1'b0, 3'b111, 32'h201, 32'h0, 32'h0, 0, 1'b0);
    access(1'b1, 3'b000, 32'h203, 32'hA5A5A5C3, 32'h0, 1, 1'b0);
    access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 2, 1'b0);
    // Start pulsed in REQ and DONE must be ignored.
    access(1'b0, 3'b010, 32'h400, 32'h0, 32'h13572468, 4, 1'b1);

    // Reset in the middle of a request aborts it.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_req_up", 32'(mem_req), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_load = '0;
    chk("abort_req", 32'(mem_req), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_load_data", load_data, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 32'(done), 0);
      mem_ack = 1'b1;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    access(1'b0, 3'b010, 32'h600, 32'h0, 32'h89ABCDEF, 1, 1'b0);
    chk("pin_after_reset", load_data, 32'h89ABCDEF);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address, plus rs2 as store data, and performs RISC-V byte, halfword and word loads and stores over a single-outstanding req/ack data-memory bus. Loaded data is returned sign- or zero-extended to the writeback path. Misaligned and illegal accesses are reported to the control FSM without touching memory.

Parameters:
XLEN, 32, data and address width; only 32 is supported.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request from the control FSM; sampled only in IDLE.
is_store  input  1  1 = store, 0 = load.
funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
addr  input  32  effective address, taken from the ALU output.
store_data  input  32  rs2 value.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when the access completes or faults.
misaligned  output  1  pulse coincident with done for a misaligned access.
illegal  output  1  pulse coincident with done for an unsupported funct3/is_store combination.
load_data  output  32  extended load result; holds until the next successful load.
mem_req  output  1  bus request; held until mem_ack.
mem_we  output  1  write enable; valid while mem_req is high.
mem_addr  output  32  word-aligned address: {addr[31:2], 2'b00}.
mem_wdata  output  32  lane-replicated store data.
mem_wstrb  output  4  byte-lane strobes; 0000 for loads.
mem_ack  input  1  completion strobe; for loads, mem_rdata is valid in the same cycle.
mem_rdata  input  32  read data.

Behaviour:
- Reset: state IDLE; all outputs are 0, including load_data. Reset asserted mid-access aborts it: mem_req is 0 after that edge and no done is produced.
- FSM states: IDLE, REQ, DONE.
- IDLE with start=1:
  - latch is_store, funct3, addr and store_data;
  - if the access is legal and aligned, go to REQ;
  - otherwise go to DONE with the matching fault flag set.
- In IDLE, start=0 and mem_ack are ignored. In other states, start is ignored (not queued).
- Legality:
  - funct3 of 011, 110 or 111 is illegal;
  - a store with funct3 100 or 101 is illegal;
  - illegal takes priority over misaligned.
- Alignment:
  - H/HU requires addr[0]=0;
  - W requires addr[1:0]=00;
  - B/BU is always aligned.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are driven from the latched values and stay stable until ack;
  - mem_ack may arrive in the first REQ cycle;
  - on ack, capture the load result (loads only) and go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. The earliest new start is accepted the cycle after DONE.
- Latency: start at cycle t gives mem_req at t+1. mem_ack at cycle k gives done at k+1, with load_data valid from k+1. A faulted access gives done at t+1.
- Store lanes, where o = addr[1:0]:
  - SB: wdata = {4{sd[7:0]}}, wstrb = 0001 << o;
  - SH: wdata = {2{sd[15:0]}}, wstrb = 0011 (o=00) or 1100 (o=10);
  - SW: wdata = sd, wstrb = 1111.
- Loads: shift mem_rdata right by 8*o, then:
  - B sign-extends bit 7;
  - BU zero-extends;
  - H sign-extends bit 15;
  - HU zero-extends;
  - W passes through.
- load_data is not modified by stores or faulted accesses.
- mem_ack outside REQ is ignored.

Test Plan:
- LW, addr=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after req -> mem_addr=0x100, mem_wstrb=0000; done 1 cycle after ack; load_data=0xDEADBEEF.
- LB addr=0x103, rdata=0x80FF_1234 -> load_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
- SH addr=0x206, store_data=0x1234ABCD, ack in first REQ cycle -> mem_addr=0x204, mem_wdata=0xABCDABCD, mem_wstrb=1100, mem_we=1; done next cycle; load_data unchanged.
- LW addr=0x102 -> no mem_req; done+misaligned at t+1. SB with funct3=100 -> done+illegal, no mem_req.
- Second start pulsed while in REQ -> ignored; exactly one mem_req transaction and one done.
- reset asserted during REQ -> mem_req=0 and busy=0 after the edge, done never pulses, load_data=0; a new LW completes normally afterwards.
